// File: rtl/config_memory_pkg.sv
// ----------------------------------------------------------------------------
// config_memory_pkg: states, channel word map and address decode for the sequencer
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package config_memory_pkg;

  typedef enum logic [1:0] {
    ST_BOOT    = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_RUN     = 2'd2,
    ST_RD_WAIT = 2'd3
  } state_t;

  localparam int unsigned WORDS_PER_CH = 6;

  localparam logic [2:0] W_IP   = 3'd0;
  localparam logic [2:0] W_MASK = 3'd1;
  localparam logic [2:0] W_GW   = 3'd2;
  localparam logic [2:0] W_TGT  = 3'd3;
  localparam logic [2:0] W_MACH = 3'd4;
  localparam logic [2:0] W_MACL = 3'd5;

  localparam int unsigned RD_LAT = 2;

  typedef struct packed {
    logic       hit;
    logic [7:0] ch;
    logic [2:0] word;
  } word_tag_t;

  // Addresses below base wrap to a huge offset and therefore miss.
  function automatic word_tag_t decode_addr(input logic [9:0] addr,
                                            input logic [9:0] base,
                                            input int unsigned n_ch);
    word_tag_t   t;
    int unsigned off;
    off    = 32'(addr) - 32'(base);
    t.hit  = off < n_ch * WORDS_PER_CH;
    t.ch   = 8'(off / WORDS_PER_CH);
    t.word = 3'(off % WORDS_PER_CH);
    return t;
  endfunction

endpackage

`default_nettype wire

// File: rtl/config_memory_sequencer.sv
// ----------------------------------------------------------------------------
// config_memory_sequencer: boots per-channel network config from BRAM, serves host access
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module config_memory_sequencer
  import config_memory_pkg::*;
#(
  parameter int          N_CH         = 8,
  parameter logic [9:0]  BASE_ADDR    = 10'd0,
  parameter logic [31:0] DEF_IP_BASE  = 32'h0a0000ff,
  parameter logic [31:0] DEF_NETMASK  = 32'hff000000,
  parameter logic [31:0] DEF_GATEWAY  = 32'h0a000001,
  parameter logic [31:0] DEF_TARGET   = 32'h0a000001,
  parameter logic [47:0] DEF_MAC_BASE = 48'h001b1affff00
) (
  input  logic               clk,
  input  logic               reset_n,
  output logic               mem_en_o,
  output logic               mem_we_o,
  output logic [9:0]         mem_addr_o,
  output logic [31:0]        mem_din_o,
  input  logic [31:0]        mem_dout_i,
  input  logic               host_req_valid_i,
  output logic               host_req_ready_o,
  input  logic               host_req_we_i,
  input  logic [9:0]         host_req_addr_i,
  input  logic [31:0]        host_req_wdata_i,
  output logic               host_rsp_valid_o,
  output logic [31:0]        host_rsp_rdata_o,
  input  logic               reload_i,
  output logic               cfg_valid_o,
  output logic               cfg_busy_o,
  output logic [N_CH*32-1:0] ipaddr_o,
  output logic [N_CH*32-1:0] netmask_o,
  output logic [N_CH*32-1:0] gateway_o,
  output logic [N_CH*32-1:0] targetip_o,
  output logic [N_CH*48-1:0] macaddr_o
);

  localparam logic [9:0] c_last = 10'(N_CH * WORDS_PER_CH - 1);

  state_t     r_state;
  logic [9:0] r_boot_cnt;
  logic [1:0] r_rd_cnt;
  logic       r_boot_rd;
  logic       r_tag_a_v, r_tag_b_v;
  word_tag_t  r_tag_a, r_tag_b;
  logic       r_reload_pend;

  logic       w_hs;
  logic       w_reload;
  word_tag_t  w_wr_tag;
  logic       w_ap_en;
  word_tag_t  w_ap_tag;
  logic [31:0] w_ap_data;
  logic       w_ap_restore;

  assign w_hs     = host_req_valid_i && host_req_ready_o;
  assign w_reload = r_reload_pend || reload_i;
  assign w_wr_tag = decode_addr(mem_addr_o, BASE_ADDR, N_CH);

  // Shared apply path: boot returns skip zero words, host writes of zero restore defaults.
  always_comb begin
    w_ap_en      = 1'b0;
    w_ap_tag     = r_tag_b;
    w_ap_data    = mem_dout_i;
    w_ap_restore = 1'b0;
    if (r_tag_b_v) begin
      w_ap_en = r_tag_b.hit && (mem_dout_i != '0);
    end else if (mem_we_o) begin
      w_ap_tag     = w_wr_tag;
      w_ap_en      = w_wr_tag.hit;
      w_ap_data    = mem_din_o;
      w_ap_restore = (mem_din_o == '0);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tag_a_v <= 1'b0;
      r_tag_b_v <= 1'b0;
      r_tag_a   <= '0;
      r_tag_b   <= '0;
    end else begin
      r_tag_a_v <= r_boot_rd;
      r_tag_a   <= w_wr_tag;
      r_tag_b_v <= r_tag_a_v;
      r_tag_b   <= r_tag_a;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state          <= ST_BOOT;
      r_boot_cnt       <= '0;
      r_rd_cnt         <= '0;
      r_boot_rd        <= 1'b0;
      r_reload_pend    <= 1'b0;
      mem_en_o         <= 1'b0;
      mem_we_o         <= 1'b0;
      mem_addr_o       <= '0;
      mem_din_o        <= '0;
      host_req_ready_o <= 1'b0;
      host_rsp_valid_o <= 1'b0;
      host_rsp_rdata_o <= '0;
      cfg_valid_o      <= 1'b0;
      cfg_busy_o       <= 1'b1;
    end else begin
      host_rsp_valid_o <= 1'b0;
      r_boot_rd        <= 1'b0;
      case (r_state)
        ST_BOOT: begin
          mem_en_o      <= 1'b1;
          mem_we_o      <= 1'b0;
          mem_addr_o    <= BASE_ADDR + r_boot_cnt;
          r_boot_rd     <= 1'b1;
          r_reload_pend <= 1'b0;
          if (r_boot_cnt == c_last) begin
            r_boot_cnt <= '0;
            r_state    <= ST_DRAIN;
          end else begin
            r_boot_cnt <= r_boot_cnt + 10'd1;
          end
        end
        ST_DRAIN: begin
          mem_en_o      <= 1'b0;
          r_reload_pend <= 1'b0;
          // Last word is being applied once the final tag is alone in the pipe.
          if (r_tag_b_v && !r_tag_a_v) begin
            r_state          <= ST_RUN;
            cfg_valid_o      <= 1'b1;
            cfg_busy_o       <= 1'b0;
            host_req_ready_o <= 1'b1;
          end
        end
        ST_RUN: begin
          r_reload_pend <= w_reload;
          if (mem_we_o) begin
            mem_en_o         <= 1'b0;
            mem_we_o         <= 1'b0;
            host_req_ready_o <= 1'b1;
          end else if (w_hs) begin
            mem_en_o         <= 1'b1;
            mem_we_o         <= host_req_we_i;
            mem_addr_o       <= host_req_addr_i;
            host_req_ready_o <= 1'b0;
            if (host_req_we_i) begin
              mem_din_o <= host_req_wdata_i;
            end else begin
              r_state  <= ST_RD_WAIT;
              r_rd_cnt <= '0;
            end
          end else if (w_reload) begin
            r_state          <= ST_BOOT;
            r_boot_cnt       <= '0;
            r_reload_pend    <= 1'b0;
            cfg_busy_o       <= 1'b1;
            host_req_ready_o <= 1'b0;
          end
        end
        ST_RD_WAIT: begin
          mem_en_o      <= 1'b0;
          r_reload_pend <= w_reload;
          if (r_rd_cnt == 2'(RD_LAT)) begin
            host_rsp_valid_o <= 1'b1;
            host_rsp_rdata_o <= mem_dout_i;
            host_req_ready_o <= 1'b1;
            r_state          <= ST_RUN;
          end else begin
            r_rd_cnt <= r_rd_cnt + 2'd1;
          end
        end
        default: r_state <= ST_BOOT;
      endcase
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    localparam logic [31:0] c_def_ip  = DEF_IP_BASE + (32'(c) << 16);
    localparam logic [47:0] c_def_mac = DEF_MAC_BASE + 48'(c);

    logic [31:0] r_ip, r_mask, r_gw, r_tgt;
    logic [47:0] r_mac;
    logic        w_sel;

    assign w_sel = w_ap_en && (w_ap_tag.ch == 8'(c));

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_ip   <= c_def_ip;
        r_mask <= DEF_NETMASK;
        r_gw   <= DEF_GATEWAY;
        r_tgt  <= DEF_TARGET;
        r_mac  <= c_def_mac;
      end else if (w_sel) begin
        case (w_ap_tag.word)
          W_IP:    r_ip         <= w_ap_restore ? c_def_ip          : w_ap_data;
          W_MASK:  r_mask       <= w_ap_restore ? DEF_NETMASK       : w_ap_data;
          W_GW:    r_gw         <= w_ap_restore ? DEF_GATEWAY       : w_ap_data;
          W_TGT:   r_tgt        <= w_ap_restore ? DEF_TARGET        : w_ap_data;
          W_MACH:  r_mac[47:16] <= w_ap_restore ? c_def_mac[47:16]  : w_ap_data;
          W_MACL:  r_mac[15:0]  <= w_ap_restore ? c_def_mac[15:0]   : w_ap_data[31:16];
          default: ;
        endcase
      end
    end

    assign ipaddr_o[c*32 +: 32]   = r_ip;
    assign netmask_o[c*32 +: 32]  = r_mask;
    assign gateway_o[c*32 +: 32]  = r_gw;
    assign targetip_o[c*32 +: 32] = r_tgt;
    assign macaddr_o[c*48 +: 48]  = r_mac;
  end

endmodule

`default_nettype wire

// File: tb/tb_config_memory_sequencer.sv
// ----------------------------------------------------------------------------
// tb_config_memory_sequencer: directed bench with BRAM model and read-response scoreboard
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_config_memory_sequencer;

  localparam int N_CH = 8;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              mem_en_o, mem_we_o;
  logic [9:0]        mem_addr_o;
  logic [31:0]       mem_din_o;
  logic [31:0]       mem_dout_i = '0;
  logic              host_req_valid_i = 1'b0;
  logic              host_req_ready_o;
  logic              host_req_we_i = 1'b0;
  logic [9:0]        host_req_addr_i = '0;
  logic [31:0]       host_req_wdata_i = '0;
  logic              host_rsp_valid_o;
  logic [31:0]       host_rsp_rdata_o;
  logic              reload_i = 1'b0;
  logic              cfg_valid_o, cfg_busy_o;
  logic [N_CH*32-1:0] ipaddr_o, netmask_o, gateway_o, targetip_o;
  logic [N_CH*48-1:0] macaddr_o;

  config_memory_sequencer #(.N_CH(N_CH)) dut (
    .clk(clk), .reset_n(reset_n),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_din_o(mem_din_o), .mem_dout_i(mem_dout_i),
    .host_req_valid_i(host_req_valid_i), .host_req_ready_o(host_req_ready_o),
    .host_req_we_i(host_req_we_i), .host_req_addr_i(host_req_addr_i),
    .host_req_wdata_i(host_req_wdata_i),
    .host_rsp_valid_o(host_rsp_valid_o), .host_rsp_rdata_o(host_rsp_rdata_o),
    .reload_i(reload_i), .cfg_valid_o(cfg_valid_o), .cfg_busy_o(cfg_busy_o),
    .ipaddr_o(ipaddr_o), .netmask_o(netmask_o), .gateway_o(gateway_o),
    .targetip_o(targetip_o), .macaddr_o(macaddr_o)
  );

  always #5 clk = ~clk;

  // BRAM model: address registered, then output register -> data two cycles after issue.
  logic [31:0] mem [1024];
  logic [31:0] mem_s1 = '0;
  always @(posedge clk) begin
    if (mem_en_o) begin
      if (mem_we_o) mem[mem_addr_o] <= mem_din_o;
      mem_s1 <= mem[mem_addr_o];
    end
    mem_dout_i <= mem_s1;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin : monitor
    exp_t ex;
    #1;
    if (reset_n && host_rsp_valid_o) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected rsp: got %h expected none", host_rsp_rdata_o);
      end else begin
        ex = sb.pop_front();
        chk("rsp data", 64'(host_rsp_rdata_o), 64'(ex.data));
        chk("rsp cycle", 64'(cyc), 64'(ex.due));
      end
    end
  end

  function automatic logic [31:0] ip_of(input int c);
    return ipaddr_o[c*32 +: 32];
  endfunction

  function automatic logic [47:0] mac_of(input int c);
    return macaddr_o[c*48 +: 48];
  endfunction

  task automatic boot_wait(input string nm);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (n == 1) begin
        chk("boot first en", 64'(mem_en_o), 64'd1);
        chk("boot first addr", 64'(mem_addr_o), 64'd0);
      end
    end while (!cfg_valid_o && n < 200);
    chk(nm, 64'(n), 64'd51);
    chk("busy after boot", 64'(cfg_busy_o), 64'd0);
    chk("ready after boot", 64'(host_req_ready_o), 64'd1);
  endtask

  task automatic reset_and_release();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic host_op(input logic we, input logic [9:0] addr, input logic [31:0] wdata,
                         input logic rl, output int e);
    int tries;
    tries = 0;
    @(negedge clk);
    host_req_valid_i = 1'b1;
    host_req_we_i    = we;
    host_req_addr_i  = addr;
    host_req_wdata_i = wdata;
    while (!host_req_ready_o && tries < 100) begin
      @(negedge clk);
      tries++;
    end
    if (tries >= 100) begin
      n_vec++;
      n_err++;
      $display("FAIL ready timeout: got 0 expected 1 within 100 cycles");
    end
    reload_i = rl;
    @(posedge clk); #1;
    e = cyc;
    host_req_valid_i = 1'b0;
    reload_i = 1'b0;
  endtask

  task automatic host_write(input logic [9:0] addr, input logic [31:0] wdata);
    int e;
    host_op(1'b1, addr, wdata, 1'b0, e);
    chk("wr mem_en", 64'(mem_en_o), 64'd1);
    chk("wr mem_we", 64'(mem_we_o), 64'd1);
    chk("wr mem_addr", 64'(mem_addr_o), 64'(addr));
    chk("wr mem_din", 64'(mem_din_o), 64'(wdata));
    chk("wr ready low", 64'(host_req_ready_o), 64'd0);
    @(posedge clk); #1;
    chk("wr ready back", 64'(host_req_ready_o), 64'd1);
    chk("wr mem_we drop", 64'(mem_we_o), 64'd0);
  endtask

  task automatic host_read(input logic [9:0] addr, input logic [31:0] exp_data);
    int e;
    exp_t ex;
    host_op(1'b0, addr, 32'd0, 1'b0, e);
    ex.data = exp_data;
    ex.due  = e + 3;
    sb.push_back(ex);
    for (int i = 0; i < 3; i++) begin
      chk("rd ready low", 64'(host_req_ready_o), 64'd0);
      @(posedge clk); #1;
    end
    chk("rd ready back", 64'(host_req_ready_o), 64'd1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    logic [N_CH*32-1:0] snap_ip;
    logic [N_CH*48-1:0] snap_mac;
    int e, n;
    logic valid_ok;
    exp_t ex;

    for (int i = 0; i < 1024; i++) mem[i] = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst mem_en", 64'(mem_en_o), 64'd0);
    chk("rst ready", 64'(host_req_ready_o), 64'd0);
    chk("rst cfg_valid", 64'(cfg_valid_o), 64'd0);
    chk("rst busy", 64'(cfg_busy_o), 64'd1);
    chk("rst ip ch0", 64'(ip_of(0)), 64'h0a0000ff);
    reset_n = 1'b1;

    // Boot with all-zero BRAM
    boot_wait("boot zero valid cycle");
    chk("zero ip ch0", 64'(ip_of(0)), 64'h0a0000ff);
    chk("zero ip ch3", 64'(ip_of(3)), 64'h0a0300ff);
    chk("zero mac ch7", 64'(mac_of(7)), 64'h001b1affff07);
    chk("zero mask ch5", 64'(netmask_o[5*32 +: 32]), 64'hff000000);
    chk("zero gw ch4", 64'(gateway_o[4*32 +: 32]), 64'h0a000001);

    // Boot with channel 1 configured
    mem[6]  = 32'hc0a80a05;
    mem[10] = 32'h00112233;
    mem[11] = 32'h44550000;
    reset_and_release();
    boot_wait("boot ch1 valid cycle");
    chk("ch1 ip", 64'(ip_of(1)), 64'hc0a80a05);
    chk("ch1 mac", 64'(mac_of(1)), 64'h001122334455);
    chk("ch1 mask", 64'(netmask_o[1*32 +: 32]), 64'hff000000);
    chk("ch0 ip default", 64'(ip_of(0)), 64'h0a0000ff);
    chk("ch2 ip default", 64'(ip_of(2)), 64'h0a0200ff);
    chk("ch2 mac default", 64'(mac_of(2)), 64'h001b1affff02);

    // Host writes
    host_write(10'd12, 32'h0a0a0a0a);
    chk("wr ch2 ip", 64'(ip_of(2)), 64'h0a0a0a0a);
    host_write(10'd12, 32'h00000000);
    chk("wr0 ch2 ip restore", 64'(ip_of(2)), 64'h0a0200ff);
    snap_ip  = ipaddr_o;
    snap_mac = macaddr_o;
    host_write(10'd1000, 32'hdeadbeef);
    for (int c = 0; c < N_CH; c++) begin
      chk("oom ip unchanged", 64'(ip_of(c)), 64'(snap_ip[c*32 +: 32]));
      chk("oom mac unchanged", 64'(mac_of(c)), 64'(snap_mac[c*48 +: 48]));
    end
    host_read(10'd1000, 32'hdeadbeef);

    // Write then read back
    host_write(10'd12, 32'h12345678);
    chk("wr ch2 ip 2", 64'(ip_of(2)), 64'h12345678);
    host_read(10'd12, 32'h12345678);
    chk("read no shadow change", 64'(ip_of(2)), 64'h12345678);

    // Reload in the same cycle as an accepted read
    host_write(10'd0, 32'h01020304);
    chk("wr ch0 ip", 64'(ip_of(0)), 64'h01020304);
    mem[0] = 32'h00000000;
    mem[6] = 32'h0b0b0b0b;
    host_op(1'b0, 10'd1000, 32'd0, 1'b1, e);
    ex.data = 32'hdeadbeef;
    ex.due  = e + 3;
    sb.push_back(ex);
    for (int i = 0; i < 3; i++) begin
      chk("rl busy low", 64'(cfg_busy_o), 64'd0);
      @(posedge clk); #1;
    end
    chk("rl rsp ready", 64'(host_req_ready_o), 64'd1);
    chk("rl rsp busy", 64'(cfg_busy_o), 64'd0);
    @(posedge clk); #1;
    chk("rl busy rise", 64'(cfg_busy_o), 64'd1);
    chk("rl ready low", 64'(host_req_ready_o), 64'd0);
    chk("rl rsp first", 64'(sb.size()), 64'd0);
    n = 0;
    valid_ok = 1'b1;
    do begin
      @(posedge clk); #1;
      n++;
      if (!cfg_valid_o) valid_ok = 1'b0;
    end while (cfg_busy_o && n < 200);
    chk("rl duration", 64'(n), 64'd51);
    chk("rl cfg_valid held", 64'(valid_ok), 64'd1);
    chk("rl ready back", 64'(host_req_ready_o), 64'd1);
    chk("rl ch0 zero kept", 64'(ip_of(0)), 64'h01020304);
    chk("rl ch1 ip", 64'(ip_of(1)), 64'h0b0b0b0b);
    chk("rl ch2 ip", 64'(ip_of(2)), 64'h12345678);
    chk("rl ch1 mac", 64'(mac_of(1)), 64'h001122334455);

    // Reset pulse mid-boot
    reset_and_release();
    repeat (20) @(posedge clk);
    #1;
    chk("midboot mem_en", 64'(mem_en_o), 64'd1);
    chk("midboot ch1 ip", 64'(ip_of(1)), 64'h0b0b0b0b);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("async mem_en", 64'(mem_en_o), 64'd0);
    chk("async ch1 ip", 64'(ip_of(1)), 64'h0a0100ff);
    chk("async busy", 64'(cfg_busy_o), 64'd1);
    @(negedge clk);
    reset_n = 1'b1;
    boot_wait("reboot valid cycle");
    chk("reboot ch1 ip", 64'(ip_of(1)), 64'h0b0b0b0b);
    chk("reboot ch0 ip", 64'(ip_of(0)), 64'h0a0000ff);

    repeat (5) @(negedge clk);
    chk("scoreboard drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
